// File: rtl/alu_mult_seq.sv
// alu_mult_seq: sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Operands are reduced to magnitudes at accept. Then RADIX_BITS multiplier bits
// are consumed per cycle. The sign is restored in a single FIX cycle.
// Optional feature: define ALU_MULT_ZERO_SKIP_EN to bypass iteration when an
// operand magnitude is zero.
module alu_mult_seq #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADIX_BITS = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result
);

  localparam int unsigned AccW     = 2 * XLEN;
  localparam int unsigned IterFull = XLEN / RADIX_BITS;
  localparam int unsigned IterWord = 32 / RADIX_BITS;
  localparam int unsigned CntW     = (IterFull > 1) ? $clog2(IterFull) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic [AccW-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_a, signed_b, neg_in, skip;
  logic [XLEN-1:0] opa, opb, mag_a, mag_b;
  logic [AccW-1:0] partial, acc_fix;
  logic [XLEN-1:0] sel;

  // Operand conditioning at accept: select width, decide signedness, take magnitudes.
  always_comb begin
    signed_a = !word && (op == 2'b01 || op == 2'b10);
    signed_b = !word && (op == 2'b01);
    opa = A;
    opb = B;
    if (word) begin
      opa        = '0;
      opb        = '0;
      opa[31:0]  = A[31:0];
      opb[31:0]  = B[31:0];
    end
    // Negation of the most-negative value wraps to 2^(XLEN-1), which is the
    // correct unsigned magnitude.
    mag_a  = (signed_a && A[XLEN-1]) ? -A : opa;
    mag_b  = (signed_b && B[XLEN-1]) ? -B : opb;
    neg_in = (signed_a & A[XLEN-1]) ^ (signed_b & B[XLEN-1]);
`ifdef ALU_MULT_ZERO_SKIP_EN
    skip = (mag_a == '0) || (mag_b == '0);
`else
    skip = 1'b0;
`endif
  end

  // Partial product of the shifted multiplicand and the current multiplier digit.
  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(RADIX_BITS); i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  // Sign restore and result selection used on the FIX cycle.
  always_comb begin
    acc_fix = neg_q ? -acc_q : acc_q;
    if (word_q) begin
      sel       = {XLEN{acc_fix[31]}};
      sel[31:0] = acc_fix[31:0];
    end else if (op_q == 2'b00) begin
      sel = acc_fix[XLEN-1:0];
    end else begin
      sel = acc_fix[AccW-1:XLEN];
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = op;
          word_d   = word;
          neg_d    = neg_in;
          mcand_d  = '0;
          mcand_d[XLEN-1:0] = mag_a;
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = word ? CntW'(IterWord - 1) : CntW'(IterFull - 1);
          state_d  = skip ? StFix : StBusy;
        end
      end
      StBusy: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        acc_d    = acc_fix;
        result_d = sel;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Result    = result_q;

endmodule
